// File: rtl/ap_ins_cache_pkg.sv
// ----------------------------------------------------------------------------
// Package: ap_ins_cache_pkg
// Purpose : Definitions shared by the instruction cache and the program
//           counter. The state encodings are visible to the PC through
//           st_cur_ins_cache, so SENT_INS must stay at 4'd3.
// Contents: ins_cache_state_t  - refill FSM state encodings
//           BYTES_PER_WORD     - DDR bytes per instruction word
// ----------------------------------------------------------------------------
package ap_ins_cache_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD_REQ  = 4'd1,
        LOAD_DATA = 4'd2,
        SENT_INS  = 4'd3
    } ins_cache_state_t;

    localparam int BYTES_PER_WORD = 8;

endpackage

// File: rtl/ins_cache_mem.sv
// ----------------------------------------------------------------------------
// Module : ins_cache_mem
// Purpose: Single-port synchronous RAM that holds one instruction window.
//          Writes come from the refill path and reads from the hit path. The
//          two never happen in the same cycle. The read data register is the
//          cache's registered instruction output, so only that register is
//          reset. The array itself has no reset.
// Ports  : clk, rst     - clock, synchronous active-high reset (rdata only)
//          we, re       - write enable / read enable (mutually exclusive)
//          addr         - word index within the window
//          wdata        - refill beat
//          rdata        - registered read data; holds when re is low
// ----------------------------------------------------------------------------
module ins_cache_mem #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array: written one beat at a time during a refill.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read port: the output register holds its value between hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ins_cache_refill.sv
// ----------------------------------------------------------------------------
// Module : ins_cache_refill
// Purpose: Instruction-cache responder for the program counter. It keeps one
//          window of ISA_DEPTH instructions. On a hit it returns the addressed
//          word one cycle later with ins_cache_rdy. On a window miss it
//          refills the whole window from DDR with a single read burst.
// Ports  : clk, rst                    - clock, synchronous active-high reset
//          addr_ins                    - requested word address (MSB = sentinel)
//          instruction, ins_cache_rdy  - registered instruction and its valid flag
//          st_cur_ins_cache            - current FSM state encoding
//          load_times                  - resident window index + 1 (0 = none)
//          ddr_rd_req/addr/len/rdy     - burst read request and handshake
//          ddr_rd_data/_valid          - burst beats, one word per beat
//          refill_cnt                  - completed refill counter
// Config : ICACHE_PERF_CNT_EN - when defined, refill_cnt counts completed
//          refills and wraps. When undefined, refill_cnt is tied to 0.
// ----------------------------------------------------------------------------
module ins_cache_refill
    import ap_ins_cache_pkg::*;
#(
    parameter int                        ADDR_WIDTH_MEM  = 16,
    parameter int                        ISA_DEPTH       = 64,
    parameter int                        TOTAL_ISA_DEPTH = 128,
    parameter int                        DDR_ADDR_WIDTH  = 28,
    parameter int                        ISA_WIDTH       = 64,
    parameter logic [DDR_ADDR_WIDTH-1:0] INS_DDR_BASE    = 28'h0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
    output logic [ISA_WIDTH-1:0]      instruction,
    output logic                      ins_cache_rdy,
    output logic [3:0]                st_cur_ins_cache,
    output logic [9:0]                load_times,
    output logic                      ddr_rd_req,
    output logic [DDR_ADDR_WIDTH-1:0] ddr_rd_addr,
    output logic [9:0]                ddr_rd_len,
    input  logic                      ddr_rd_rdy,
    input  logic [ISA_WIDTH-1:0]      ddr_rd_data,
    input  logic                      ddr_rd_data_valid,
    output logic [15:0]               refill_cnt
);

    localparam int OFF_W = $clog2(ISA_DEPTH);
    localparam int WIN_W = ADDR_WIDTH_MEM - OFF_W;

    ins_cache_state_t state, state_nxt;

    logic [WIN_W-1:0] addr_win;
    logic [WIN_W-1:0] cur_win;
    logic [WIN_W-1:0] res_win;
    logic             win_valid;
    logic [OFF_W-1:0] beat_cnt;
    logic             is_sentinel, is_oor, is_hit, is_miss;
    logic             enter_req, last_beat;
    logic             mem_we, mem_re;
    logic [OFF_W-1:0] mem_addr;
    logic [WIN_W:0]   lt_sum;

    assign addr_win    = addr_ins[ADDR_WIDTH_MEM-1:OFF_W];
    assign is_sentinel = addr_ins[ADDR_WIDTH_MEM-1];
    assign is_oor      = addr_ins >= ADDR_WIDTH_MEM'(TOTAL_ISA_DEPTH);
    assign is_hit      = win_valid && !is_sentinel && !is_oor && (addr_win == res_win);
    assign is_miss     = !is_sentinel && !is_oor && !is_hit;

    assign st_cur_ins_cache = state;
    assign ddr_rd_req       = (state == LOAD_REQ);
    assign lt_sum           = {1'b0, cur_win} + (WIN_W + 1)'(1);

    // Next-state logic and RAM port control. The window index is latched
    // whenever a miss launches a refill, from IDLE or from SENT_INS.
    always_comb begin
        state_nxt = state;
        enter_req = 1'b0;
        last_beat = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = addr_ins[OFF_W-1:0];
        case (state)
            IDLE: begin
                if (is_miss) begin
                    state_nxt = LOAD_REQ;
                    enter_req = 1'b1;
                end
            end
            LOAD_REQ: begin
                if (ddr_rd_rdy) begin
                    state_nxt = LOAD_DATA;
                end
            end
            LOAD_DATA: begin
                mem_addr = beat_cnt;
                if (ddr_rd_data_valid) begin
                    mem_we = 1'b1;
                    if (beat_cnt == OFF_W'(ISA_DEPTH - 1)) begin
                        last_beat = 1'b1;
                        state_nxt = SENT_INS;
                    end
                end
            end
            SENT_INS: begin
                if (is_hit) begin
                    mem_re = 1'b1;
                end else if (is_miss) begin
                    state_nxt = LOAD_REQ;
                    enter_req = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, window bookkeeping and request registers. The request address and
    // length are registered when the refill is launched, so they stay stable
    // while ddr_rd_rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cur_win       <= '0;
            res_win       <= '0;
            win_valid     <= 1'b0;
            beat_cnt      <= '0;
            load_times    <= '0;
            ddr_rd_addr   <= '0;
            ddr_rd_len    <= '0;
            ins_cache_rdy <= 1'b0;
        end else begin
            state         <= state_nxt;
            ins_cache_rdy <= mem_re;
            if (enter_req) begin
                cur_win     <= addr_win;
                win_valid   <= 1'b0;
                beat_cnt    <= '0;
                ddr_rd_len  <= 10'(ISA_DEPTH);
                ddr_rd_addr <= INS_DDR_BASE + DDR_ADDR_WIDTH'(addr_win) *
                               DDR_ADDR_WIDTH'(ISA_DEPTH * BYTES_PER_WORD);
            end
            if (mem_we) begin
                beat_cnt <= beat_cnt + OFF_W'(1);
            end
            if (last_beat) begin
                res_win    <= cur_win;
                win_valid  <= 1'b1;
                load_times <= (lt_sum > (WIN_W + 1)'(1023)) ? 10'd1023 : lt_sum[9:0];
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    // Completed refills. The counter wraps naturally at 16'hFFFF.
    always_ff @(posedge clk) begin
        if (rst) begin
            refill_cnt <= '0;
        end else if (last_beat) begin
            refill_cnt <= refill_cnt + 16'd1;
        end
    end
`else
    assign refill_cnt = '0;
`endif

    ins_cache_mem #(
        .DEPTH (ISA_DEPTH),
        .WIDTH (ISA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (ddr_rd_data),
        .rdata (instruction)
    );

endmodule

// File: tb/tb_ins_cache_refill.sv
// ----------------------------------------------------------------------------
// Testbench for ins_cache_refill. A small DDR responder returns the global word
// index as the data of each beat. Every hit therefore has an easily derived
// expected instruction. Expectations are queued when an address is applied and
// popped one cycle later.
// ----------------------------------------------------------------------------
module tb_ins_cache_refill;

    localparam int          ISA_DEPTH = 64;
    localparam int          TOTAL     = 128;
    localparam logic [27:0] BASE      = 28'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr_ins;
    logic [63:0] instruction;
    logic        ins_cache_rdy;
    logic [3:0]  st_cur_ins_cache;
    logic [9:0]  load_times;
    logic        ddr_rd_req;
    logic [27:0] ddr_rd_addr;
    logic [9:0]  ddr_rd_len;
    logic        ddr_rd_rdy;
    logic [63:0] ddr_rd_data;
    logic        ddr_rd_data_valid;
    logic [15:0] refill_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [64:0] exp_q[$];
    bit          m_valid   = 1'b0;
    int          m_win     = 0;
    logic [63:0] m_last    = '0;
    int          m_refills = 0;

    always #5 clk = ~clk;

    ins_cache_refill dut (
        .clk               (clk),
        .rst               (rst),
        .addr_ins          (addr_ins),
        .instruction       (instruction),
        .ins_cache_rdy     (ins_cache_rdy),
        .st_cur_ins_cache  (st_cur_ins_cache),
        .load_times        (load_times),
        .ddr_rd_req        (ddr_rd_req),
        .ddr_rd_addr       (ddr_rd_addr),
        .ddr_rd_len        (ddr_rd_len),
        .ddr_rd_rdy        (ddr_rd_rdy),
        .ddr_rd_data       (ddr_rd_data),
        .ddr_rd_data_valid (ddr_rd_data_valid),
        .refill_cnt        (refill_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive an address and queue the response the next cycle should show.
    task automatic applyStimulus(input logic [15:0] a);
        addr_ins = a;
        if (m_valid && !a[15] && int'(a) < TOTAL && int'(a) / ISA_DEPTH == m_win) begin
            m_last = 64'(a);
            exp_q.push_back({1'b1, m_last});
        end else begin
            exp_q.push_back({1'b0, m_last});
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [64:0] e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_rdy"}, 64'(ins_cache_rdy), 64'(e[64]));
            chk({tag, "_instr"}, instruction, e[63:0]);
        end
    endtask

    task automatic wait_req();
        for (int k = 0; k < 20 && !ddr_rd_req; k++) @(negedge clk);
        chk("req_seen", 64'(ddr_rd_req), 64'd1);
    endtask

    task automatic send_beats(input int win, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            ddr_rd_data_valid = 1'b1;
            ddr_rd_data       = 64'(win * ISA_DEPTH + i);
            @(negedge clk);
        end
        ddr_rd_data_valid = 1'b0;
    endtask

    task automatic refill_cnt_check();
`ifdef ICACHE_PERF_CNT_EN
        chk("refill_cnt", 64'(refill_cnt), 64'(m_refills));
`else
        chk("refill_cnt", 64'(refill_cnt), 64'd0);
`endif
    endtask

    // Full refill of window win, starting from a pending or upcoming request.
    task automatic do_refill(input int win, input int stall);
        m_valid = 1'b0;
        wait_req();
        for (int s = 0; s < stall; s++) begin
            ddr_rd_data_valid = 1'b1;
            ddr_rd_data       = 64'hDEAD_BEEF_0000_0000;
            chk("stall_req", 64'(ddr_rd_req), 64'd1);
            chk("stall_addr", 64'(ddr_rd_addr), 64'(BASE + 28'(win * ISA_DEPTH * 8)));
            chk("stall_len", 64'(ddr_rd_len), 64'd64);
            @(negedge clk);
        end
        ddr_rd_data_valid = 1'b0;
        chk("req_addr", 64'(ddr_rd_addr), 64'(BASE + 28'(win * ISA_DEPTH * 8)));
        chk("req_len", 64'(ddr_rd_len), 64'd64);
        ddr_rd_rdy = 1'b1;
        @(negedge clk);
        ddr_rd_rdy = 1'b0;
        chk("st_load_data", 64'(st_cur_ins_cache), 64'd2);
        chk("req_dropped", 64'(ddr_rd_req), 64'd0);
        send_beats(win, 0, ISA_DEPTH);
        m_valid = 1'b1;
        m_win   = win;
        m_refills++;
        chk("st_sent", 64'(st_cur_ins_cache), 64'd3);
        chk("load_times", 64'(load_times), 64'(win + 1));
        refill_cnt_check();
    endtask

    initial begin
        rst               = 1'b1;
        addr_ins          = '0;
        ddr_rd_rdy        = 1'b0;
        ddr_rd_data       = '0;
        ddr_rd_data_valid = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_st", 64'(st_cur_ins_cache), 64'd0);
        chk("rst_lt", 64'(load_times), 64'd0);
        chk("rst_rdy", 64'(ins_cache_rdy), 64'd0);
        chk("rst_req", 64'(ddr_rd_req), 64'd0);
        chk("rst_instr", instruction, 64'd0);
        chk("rst_addr", 64'(ddr_rd_addr), 64'd0);
        chk("rst_len", 64'(ddr_rd_len), 64'd0);
        refill_cnt_check();
        rst = 1'b0;

        // 1: cold miss on word 0, then a hit on word 5
        $display("[TB] step 1: cold refill of window 0");
        do_refill(0, 0);
        applyStimulus(16'd5);  checkOutput("t1_hit5");
        applyStimulus(16'd63); checkOutput("t1_hit63");

        // 2: sequential run into window 1
        $display("[TB] step 2: miss at word 64");
        applyStimulus(16'd64); checkOutput("t2_miss");
        do_refill(1, 0);
        applyStimulus(16'd64); checkOutput("t2_hit64");
        applyStimulus(16'd67); checkOutput("t2_hit67");

        // Back to window 0 before the sentinel step
        applyStimulus(16'd10); checkOutput("t3_pre_miss");
        do_refill(0, 0);

        // 3: sentinel holds, then a jump into window 1
        $display("[TB] step 3: sentinel then jump");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'h8000); checkOutput("t3_sentinel");
            chk("t3_no_req", 64'(ddr_rd_req), 64'd0);
        end
        applyStimulus(16'd70); checkOutput("t3_miss70");
        do_refill(1, 0);
        applyStimulus(16'd70); checkOutput("t3_hit70");

        // 4: out-of-range address, with stray beats that must be ignored
        $display("[TB] step 4: out of range");
        ddr_rd_data_valid = 1'b1;
        ddr_rd_data       = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'd128); checkOutput("t4_oor");
            chk("t4_no_req", 64'(ddr_rd_req), 64'd0);
        end
        ddr_rd_data_valid = 1'b0;
        chk("t4_lt", 64'(load_times), 64'd2);
        chk("t4_st", 64'(st_cur_ins_cache), 64'd3);
        applyStimulus(16'd64);  checkOutput("t4_hit64");
        applyStimulus(16'd127); checkOutput("t4_hit127");

        // 5: reset in the middle of a refill
        $display("[TB] step 5: reset mid-refill");
        applyStimulus(16'd0); checkOutput("t5_miss");
        wait_req();
        ddr_rd_rdy = 1'b1;
        @(negedge clk);
        ddr_rd_rdy = 1'b0;
        send_beats(0, 0, 10);
        ddr_rd_data_valid = 1'b1;
        ddr_rd_data       = 64'hFFFF_0000_FFFF_0000;
        rst = 1'b1;
        @(negedge clk);
        m_valid = 1'b0;
        m_last  = '0;
        chk("t5_st", 64'(st_cur_ins_cache), 64'd0);
        chk("t5_lt", 64'(load_times), 64'd0);
        chk("t5_req", 64'(ddr_rd_req), 64'd0);
        chk("t5_rdy", 64'(ins_cache_rdy), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        ddr_rd_data_valid = 1'b0;
        chk("t5_restart_st", 64'(st_cur_ins_cache), 64'd1);
        do_refill(0, 0);
        applyStimulus(16'd0);  checkOutput("t5_hit0");
        applyStimulus(16'd33); checkOutput("t5_hit33");

        // 6: DDR stalls the request for 5 cycles
        $display("[TB] step 6: request back-pressure");
        applyStimulus(16'd100); checkOutput("t6_miss");
        do_refill(1, 5);
        applyStimulus(16'd100); checkOutput("t6_hit100");
        applyStimulus(16'd64);  checkOutput("t6_hit64");

        if (exp_q.size() != 0) chk("sb_leftover", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
